voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Scheduler between the song reader and the bank of note players. Accepts (note, duration)
//  requests over a valid/ready handshake, assigns each to the lowest-index free voice, counts
//  its duration down on beat ticks, and frees the voice on expiry. Honours play/pause and a
//  flush for song change. Its voice outputs feed the note players.
// PARAMETERS
//  NUM_VOICES  3  number of note-player voices shared (1..8)
//  NOTE_W      6  note code width; code 0 = rest (voice held, player outputs silence)
//  DUR_W       6  duration width, in beats
// PORTS
//  clk           input   1                     system clock
//  reset         input   1                     asynchronous, active-low reset
//  play          input   1                     1 = playing, 0 = paused
//  flush         input   1                     1-cycle pulse: drop all voices (song change)
//  beat          input   1                     1-cycle beat tick from the beat generator
//  note_valid    input   1                     request valid from song reader
//  note_in       input   NOTE_W                requested note code
//  dur_in        input   DUR_W                 requested duration, beats
//  note_ready    output  1                     request accepted this cycle when high with note_valid
//  voice_load    output  NUM_VOICES            one-hot 1-cycle pulse: voice i (re)starts its note
//  voice_note    output  NUM_VOICES*NOTE_W     note per voice, voice i at [i*NOTE_W +: NOTE_W]
//  voice_active  output  NUM_VOICES            voice i currently holds a note
//  all_idle      output  1                     no voice active
// BEHAVIOUR
//  - Reset (reset==0, async): all counters 0, voice_note 0, voice_load 0, voice_active 0,
//    all_idle 1; note_ready low while reset asserted.
//  - State per voice: IDLE (count==0) / BUSY (count>0). voice_active[i] = (count_i != 0), registered.
//  - note_ready = play & ~flush & (some voice IDLE), combinational from registered state only;
//    must not depend on note_valid.
//  - Accept = note_valid & note_ready. Target = lowest index IDLE voice (fixed priority).
//    Edge after accept: count_target <= dur_in, voice_note[target] <= note_in,
//    voice_load[target] = 1 for exactly one cycle. Latency accept->voice_load: 1 cycle.
//  - dur_in == 0: request accepted (handshake completes), no voice loaded, no voice_load pulse.
//  - Countdown: on beat & play, every BUSY voice decrements by 1; 1->0 frees the voice at
//    that edge. voice_note retains its last value after expiry (players gate on voice_active).
//  - Same-cycle load + beat: the newly loaded voice takes dur_in undecremented; other voices
//    decrement normally. A voice expiring on this edge is not eligible as target this cycle
//    (eligibility uses registered state); it is eligible the next cycle.
//  - Pause (play==0): counts frozen, beats ignored, note_ready low, voice_active unchanged.
//  - flush: highest priority after reset. Next edge: all counts 0, voice_load 0,
//    voice_note 0; a request presented in the flush cycle is not accepted (ready low).
//  - All voices BUSY: note_ready low; request held by song reader until a voice frees.
//  - all_idle = ~|voice_active (registered state, no extra latency).
//  - No arithmetic overflow: counts only load or decrement from nonzero.
// STRUCTURE
//  - Shared package: NOTE_W, DUR_W defaults, NOTE_REST = 0 constant.
//  - Sub-module voice_slot (one per voice, generate loop): count + note regs,
//    inputs load/note/dur/tick/flush, outputs active/note/load pulse.
//  - Top: lowest-index-free priority encoder, handshake, all_idle reduction.
// TESTING
//  1 Reset: reset=0 mid-run with 2 voices busy -> all outputs reset values immediately;
//    after release, play=1 -> note_ready=1, all_idle=1.
//  2 Allocation: play=1, three back-to-back requests (note 12/dur 4, 20/2, 7/1) -> voice_load
//    001,010,100 on cycles 1,2,3 after each accept; 4th request stalls (note_ready=0).
//  3 Expiry: continue 2 with beats every 8 cycles -> voice2 frees after 1 beat, voice1 after 2,
//    voice0 after 4; stalled request lands on voice2 the cycle after voice2 frees.
//  4 Corners: beat coinciding with accept of dur 3 -> new voice still needs 3 beats;
//    dur_in=0 accepted with no voice_load and voice_active unchanged.
//  5 Pause/flush: play=0 for 5 beats -> counts unchanged, note_ready=0; flush with 3 busy ->
//    next cycle voice_active=000, all_idle=1, request in flush cycle not accepted.
//  6 Random: constrained-random valid/beat/play against a reference model, NUM_VOICES=1 and 4;
//    check one-hot voice_load and no load onto a busy voice.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared constants for the voice allocator and its per-voice slots.
`default_nettype none

package voice_allocator_pkg;

   localparam int unsigned DEF_NOTE_W = 6;
   localparam int unsigned DEF_DUR_W  = 6;
   localparam int unsigned NOTE_REST  = 0;

endpackage

`default_nettype wire

// File: rtl/voice_allocator_voice_slot.sv
// One note-player voice: holds a note and counts its remaining duration down on ticks.
`default_nettype none

module voice_slot
   import voice_allocator_pkg::*;
#(
   parameter int unsigned NOTE_W = DEF_NOTE_W,
   parameter int unsigned DUR_W  = DEF_DUR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              tick_i,
   input  logic              load_i,
   input  logic [NOTE_W-1:0] note_i,
   input  logic [DUR_W-1:0]  dur_i,
   output logic              active_o,
   output logic [NOTE_W-1:0] note_o,
   output logic              load_o
);

   logic [DUR_W-1:0]  count_q, count_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              load_q, load_d;

   // A load only ever targets an idle slot, so it never competes with a decrement.
   always_comb begin
      count_d = count_q;
      note_d  = note_q;
      load_d  = load_i & ~flush_i;
      if (flush_i) begin
         count_d = '0;
         note_d  = NOTE_W'(NOTE_REST);
      end else if (load_i) begin
         count_d = dur_i;
         note_d  = note_i;
      end else if (tick_i && (count_q != '0)) begin
         count_d = count_q - DUR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         note_q  <= '0;
         load_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         note_q  <= note_d;
         load_q  <= load_d;
      end
   end

   assign active_o = (count_q != '0);
   assign note_o   = note_q;
   assign load_o   = load_q;

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// Assigns (note, duration) requests to the lowest-index free voice and frees voices on expiry.
`default_nettype none

module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 3,
   parameter int unsigned NOTE_W     = DEF_NOTE_W,
   parameter int unsigned DUR_W      = DEF_DUR_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         play,
   input  logic                         flush,
   input  logic                         beat,
   input  logic                         note_valid,
   input  logic [NOTE_W-1:0]            note_in,
   input  logic [DUR_W-1:0]             dur_in,
   output logic                         note_ready,
   output logic [NUM_VOICES-1:0]        voice_load,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_active,
   output logic                         all_idle
);

   logic [NUM_VOICES-1:0] free_vec;
   logic [NUM_VOICES-1:0] target_vec;
   logic [NUM_VOICES-1:0] load_vec;
   logic                  accept;
   logic                  tick;

   assign free_vec   = ~voice_active;
   // Isolate the lowest set bit: fixed priority towards voice 0.
   assign target_vec = free_vec & (~free_vec + NUM_VOICES'(1));

   assign note_ready = reset & play & ~flush & (|free_vec);
   assign accept     = note_valid & note_ready;
   assign load_vec   = (accept && (dur_in != '0)) ? target_vec : '0;
   assign tick       = beat & play;
   assign all_idle   = ~|voice_active;

   generate
      for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
         voice_slot #(
            .NOTE_W (NOTE_W),
            .DUR_W  (DUR_W)
         ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .flush_i  (flush),
            .tick_i   (tick),
            .load_i   (load_vec[i]),
            .note_i   (note_in),
            .dur_i    (dur_in),
            .active_o (voice_active[i]),
            .note_o   (voice_note[i*NOTE_W +: NOTE_W]),
            .load_o   (voice_load[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// Self-checking bench: three allocators (3, 1 and 4 voices) share stimulus against a voice-pool model.
`default_nettype none

module tb_voice_allocator;

   logic       clk = 1'b0;
   logic       reset, play, flush, beat, note_valid;
   logic [5:0] note_in, dur_in;

   logic        rdy3, idle3;
   logic [2:0]  ld3, va3;
   logic [17:0] vn3;
   logic        rdy1, idle1;
   logic [0:0]  ld1, va1;
   logic [5:0]  vn1;
   logic        rdy4, idle4;
   logic [3:0]  ld4, va4;
   logic [23:0] vn4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) u_dut (
      .clk(clk), .reset(reset), .play(play), .flush(flush), .beat(beat),
      .note_valid(note_valid), .note_in(note_in), .dur_in(dur_in),
      .note_ready(rdy3), .voice_load(ld3), .voice_note(vn3),
      .voice_active(va3), .all_idle(idle3));

   voice_allocator #(.NUM_VOICES(1), .NOTE_W(6), .DUR_W(6)) u_dut1 (
      .clk(clk), .reset(reset), .play(play), .flush(flush), .beat(beat),
      .note_valid(note_valid), .note_in(note_in), .dur_in(dur_in),
      .note_ready(rdy1), .voice_load(ld1), .voice_note(vn1),
      .voice_active(va1), .all_idle(idle1));

   voice_allocator #(.NUM_VOICES(4), .NOTE_W(6), .DUR_W(6)) u_dut4 (
      .clk(clk), .reset(reset), .play(play), .flush(flush), .beat(beat),
      .note_valid(note_valid), .note_in(note_in), .dur_in(dur_in),
      .note_ready(rdy4), .voice_load(ld4), .voice_note(vn4),
      .voice_active(va4), .all_idle(idle4));

   // Pool model: remaining beats and note per voice, per instance.
   int nv[3] = '{3, 1, 4};
   int m_cnt[3][8];
   int m_note[3][8];
   int m_load[3];
   int m_pre_act[3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_rdy(int d);
      if (!reset || !play || flush) return 1'b0;
      for (int i = 0; i < nv[d]; i++) if (m_cnt[d][i] == 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_act(int d);
      int r = 0;
      for (int i = 0; i < nv[d]; i++) if (m_cnt[d][i] != 0) r |= (1 << i);
      return r;
   endfunction

   function automatic logic [63:0] m_notes(int d);
      logic [63:0] r = '0;
      for (int i = 0; i < nv[d]; i++) r[i*6 +: 6] = m_note[d][i][5:0];
      return r;
   endfunction

   task automatic m_clear();
      for (int d = 0; d < 3; d++) begin
         m_load[d] = 0;
         for (int i = 0; i < 8; i++) begin
            m_cnt[d][i]  = 0;
            m_note[d][i] = 0;
         end
      end
   endtask

   task automatic m_edge();
      for (int d = 0; d < 3; d++) begin
         bit rdy = m_rdy(d);
         int tgt = -1;
         for (int i = 0; i < nv[d]; i++) if (m_cnt[d][i] == 0 && tgt < 0) tgt = i;
         m_pre_act[d] = m_act(d);
         m_load[d]    = 0;
         if (!reset || flush) begin
            for (int i = 0; i < 8; i++) begin
               m_cnt[d][i]  = 0;
               m_note[d][i] = 0;
            end
         end else begin
            if (beat && play)
               for (int i = 0; i < nv[d]; i++) if (m_cnt[d][i] > 0) m_cnt[d][i]--;
            if (rdy && note_valid && dur_in != 0) begin
               m_cnt[d][tgt]  = int'(dur_in);
               m_note[d][tgt] = int'(note_in);
               m_load[d]      = 1 << tgt;
            end
         end
      end
   endtask

   task automatic get_obs(input int d, output logic [63:0] rd, output logic [63:0] ld,
                          output logic [63:0] vn, output logic [63:0] va, output logic [63:0] id);
      case (d)
         0:       begin rd = 64'(rdy3); ld = 64'(ld3); vn = 64'(vn3); va = 64'(va3); id = 64'(idle3); end
         1:       begin rd = 64'(rdy1); ld = 64'(ld1); vn = 64'(vn1); va = 64'(va1); id = 64'(idle1); end
         default: begin rd = 64'(rdy4); ld = 64'(ld4); vn = 64'(vn4); va = 64'(va4); id = 64'(idle4); end
      endcase
   endtask

   task automatic check_pre();
      logic [63:0] rd, ld, vn, va, id;
      for (int d = 0; d < 3; d++) begin
         get_obs(d, rd, ld, vn, va, id);
         chk($sformatf("n%0d_note_ready", nv[d]), rd, 64'(m_rdy(d)));
      end
   endtask

   task automatic check_post();
      logic [63:0] rd, ld, vn, va, id;
      for (int d = 0; d < 3; d++) begin
         get_obs(d, rd, ld, vn, va, id);
         chk($sformatf("n%0d_voice_load", nv[d]), ld, 64'(m_load[d]));
         chk($sformatf("n%0d_voice_note", nv[d]), vn, m_notes(d));
         chk($sformatf("n%0d_voice_active", nv[d]), va, 64'(m_act(d)));
         chk($sformatf("n%0d_all_idle", nv[d]), id, 64'(m_act(d) == 0));
      end
   endtask

   // One clock: inputs already driven; ready checked before the edge, state after it.
   task automatic step();
      logic [63:0] rd, ld, vn, va, id;
      #1;
      check_pre();
      @(posedge clk);
      m_edge();
      #1;
      check_post();
      for (int d = 0; d < 3; d++) begin
         get_obs(d, rd, ld, vn, va, id);
         chk($sformatf("n%0d_load_onehot", nv[d]), 64'($onehot0(ld)), 64'd1);
         chk($sformatf("n%0d_load_on_busy", nv[d]), ld & 64'(m_pre_act[d]), 64'd0);
      end
      @(negedge clk);
   endtask

   task automatic beats(input int n);
      for (int k = 0; k < n; k++)
         for (int c = 0; c < 8; c++) begin
            beat = (c == 7);
            step();
         end
      beat = 1'b0;
   endtask

   initial begin
      reset = 1'b0; play = 1'b0; flush = 1'b0; beat = 1'b0;
      note_valid = 1'b0; note_in = '0; dur_in = '0;
      m_clear();
      for (int d = 0; d < 3; d++) m_pre_act[d] = 0;
      step();
      step();

      // Reset asserted asynchronously with two voices busy
      reset = 1'b1; play = 1'b1;
      note_valid = 1'b1; note_in = 6'd5; dur_in = 6'd9;
      step();
      note_in = 6'd6;
      step();
      note_valid = 1'b0;
      step();
      chk("pre_reset_active", 64'(va3), 64'b011);
      #2 reset = 1'b0;
      #1;
      m_clear();
      check_post();
      chk("rst_active", 64'(va3), 64'd0);
      chk("rst_idle", 64'(idle3), 64'd1);
      chk("rst_load", 64'(ld3), 64'd0);
      chk("rst_note", 64'(vn3), 64'd0);
      chk("rst_ready", 64'(rdy3), 64'd0);
      step();
      reset = 1'b1;
      #1;
      chk("post_rst_ready", 64'(rdy3), 64'd1);
      chk("post_rst_idle", 64'(idle3), 64'd1);
      step();

      // Back-to-back allocation, then a stall with all voices busy
      note_valid = 1'b1; note_in = 6'd12; dur_in = 6'd4;
      step();
      chk("alloc_load0", 64'(ld3), 64'b001);
      note_in = 6'd20; dur_in = 6'd2;
      step();
      chk("alloc_load1", 64'(ld3), 64'b010);
      note_in = 6'd7; dur_in = 6'd1;
      step();
      chk("alloc_load2", 64'(ld3), 64'b100);
      note_in = 6'd33; dur_in = 6'd5;
      #1;
      chk("stall_ready", 64'(rdy3), 64'd0);
      step();
      chk("stall_load", 64'(ld3), 64'd0);

      // Expiry on beats; the held request lands on voice 2 one cycle after it frees
      beats(1);
      chk("exp_beat1_active", 64'(va3), 64'b011);
      step();
      chk("stalled_lands_v2", 64'(ld3), 64'b100);
      chk("stalled_active", 64'(va3), 64'b111);
      note_valid = 1'b0;
      beats(1);
      chk("exp_beat2_active", 64'(va3), 64'b101);
      beats(2);
      chk("exp_beat4_active", 64'(va3), 64'b100);

      // Accept coinciding with a beat keeps the full duration
      note_valid = 1'b1; note_in = 6'd9; dur_in = 6'd3; beat = 1'b1;
      step();
      beat = 1'b0; note_valid = 1'b0;
      chk("beat_accept_load", 64'(ld3), 64'b001);
      beats(2);
      chk("beat_accept_2beats", 64'(va3), 64'b001);
      beats(1);
      chk("beat_accept_3beats", 64'(va3), 64'b000);

      // Zero-duration request completes the handshake without loading
      note_valid = 1'b1; note_in = 6'd11; dur_in = 6'd0;
      #1;
      chk("dur0_ready", 64'(rdy3), 64'd1);
      step();
      chk("dur0_load", 64'(ld3), 64'd0);
      chk("dur0_active", 64'(va3), 64'd0);

      // Pause freezes counts; flush drops everything
      dur_in = 6'd10;
      for (int k = 1; k <= 3; k++) begin
         note_in = 6'(k);
         step();
      end
      play = 1'b0; note_in = 6'd40; dur_in = 6'd4;
      beats(5);
      chk("pause_active", 64'(va3), 64'b111);
      #1;
      chk("pause_ready", 64'(rdy3), 64'd0);
      play = 1'b1; note_valid = 1'b0;
      beats(9);
      chk("pause_frozen_counts", 64'(va3), 64'b111);
      flush = 1'b1; note_valid = 1'b1; note_in = 6'd50; dur_in = 6'd7;
      #1;
      chk("flush_ready", 64'(rdy3), 64'd0);
      step();
      flush = 1'b0; note_valid = 1'b0;
      chk("flush_active", 64'(va3), 64'd0);
      chk("flush_idle", 64'(idle3), 64'd1);
      chk("flush_load", 64'(ld3), 64'd0);
      chk("flush_note", 64'(vn3), 64'd0);

      // Random traffic against the model on all three pool sizes
      for (int n = 0; n < 3000; n++) begin
         note_valid = ($urandom_range(0, 2) != 0);
         note_in    = 6'($urandom);
         dur_in     = 6'($urandom_range(0, 5));
         beat       = ($urandom_range(0, 3) == 0);
         play       = ($urandom_range(0, 9) != 0);
         flush      = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
